// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//   Round-robin arbiter with registered one-hot grant, binary grant index and
//   grant-valid flag. Every cycle with enable high the arbiter picks the first
//   active requester at or after the rotating pointer (circularly), then moves
//   the pointer to one past the winner so each requester gets a fair turn.
//
//   Optional feature (macro RR_ARBITER_LOCK_EN):
//     When defined, a requester that is currently granted can hold its grant
//     by asserting lock while keeping its request up. The pointer is frozen
//     while locked, so arbitration resumes at held index + 1 when released.
//     When undefined, lock is ignored and the LOCKED state is never entered.
//
// Ports
//   clk        in   1      sole clock, rising edge
//   reset      in   1      synchronous active-high reset
//   req        in   N      request vector, bit i = requester i
//   enable     in   1      arbitration enable; low forces no grant
//   lock       in   1      grant-hold request (used only with the macro)
//   gnt        out  N      registered one-hot grant (or zero)
//   gnt_idx    out  IDX_W  registered index of granted requester (0 if none)
//   gnt_valid  out  1      registered, high iff gnt is non-zero
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N     = 8,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     req,
    input  logic             enable,
    input  logic             lock,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] w_ptr_next;
    logic [N-1:0]     r_gnt;
    logic [N-1:0]     w_gnt_next;
    logic [IDX_W-1:0] r_gnt_idx;
    logic [IDX_W-1:0] w_gnt_idx_next;
    logic             r_gnt_valid;
    logic             w_gnt_valid_next;

    // Requesters at or above the pointer get first chance; if none of them
    // is active, the lowest active requester overall wins (the wrap-around).
    logic [N-1:0]     w_mask;
    logic [N-1:0]     w_req_hi;
    logic             w_hi_found;
    logic [IDX_W-1:0] w_hi_idx;
    logic [IDX_W-1:0] w_lo_idx;
    logic             w_any_req;
    logic [IDX_W-1:0] w_win_idx;
    logic [IDX_W-1:0] w_win_inc;
    logic             w_lock_hold;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_mask
            assign w_mask[gi] = (int'(r_ptr) <= gi);
        end
    endgenerate

    assign w_req_hi  = req & w_mask;
    assign w_any_req = |req;

    // Lowest-index priority encoders: scanning downward leaves the lowest hit.
    always_comb begin
        w_hi_found = 1'b0;
        w_hi_idx   = '0;
        w_lo_idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_req_hi[i]) begin
                w_hi_found = 1'b1;
                w_hi_idx   = IDX_W'(i);
            end
            if (req[i]) begin
                w_lo_idx = IDX_W'(i);
            end
        end
    end

    assign w_win_idx = w_hi_found ? w_hi_idx : w_lo_idx;
    // Explicit wrap keeps the pointer below N for non-power-of-two N.
    assign w_win_inc = (w_win_idx == IDX_W'(N - 1)) ? '0 : (w_win_idx + 1'b1);

`ifdef RR_ARBITER_LOCK_EN
    // Hold only while the current owner still requests; r_gnt is one-hot of
    // r_gnt_idx, so masking req with it tests req[r_gnt_idx].
    assign w_lock_hold = lock & r_gnt_valid & (|(req & r_gnt));
`else
    assign w_lock_hold = lock & 1'b0;
`endif

    always_comb begin
        w_state_next     = r_state;
        w_ptr_next       = r_ptr;
        w_gnt_next       = r_gnt;
        w_gnt_idx_next   = r_gnt_idx;
        w_gnt_valid_next = r_gnt_valid;

        if (!enable) begin
            // enable dominates lock; pointer is left where it was
            w_state_next     = ST_IDLE;
            w_gnt_next       = '0;
            w_gnt_idx_next   = '0;
            w_gnt_valid_next = 1'b0;
        end else if ((r_state != ST_IDLE) && w_lock_hold) begin
            // grant and pointer held by the defaults
            w_state_next = ST_LOCKED;
        end else if (w_any_req) begin
            w_state_next     = ST_GRANT;
            w_gnt_next       = N'(1) << w_win_idx;
            w_gnt_idx_next   = w_win_idx;
            w_gnt_valid_next = 1'b1;
            w_ptr_next       = w_win_inc;
        end else begin
            w_state_next     = ST_IDLE;
            w_gnt_next       = '0;
            w_gnt_idx_next   = '0;
            w_gnt_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            r_gnt       <= '0;
            r_gnt_idx   <= '0;
            r_gnt_valid <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_ptr       <= w_ptr_next;
            r_gnt       <= w_gnt_next;
            r_gnt_idx   <= w_gnt_idx_next;
            r_gnt_valid <= w_gnt_valid_next;
        end
    end

    assign gnt       = r_gnt;
    assign gnt_idx   = r_gnt_idx;
    assign gnt_valid = r_gnt_valid;

endmodule

// File: tb/tb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rr_arbiter
//   Scoreboard bench for rr_arbiter. Each driven cycle pushes the expected
//   registered outputs (from a circular-scan reference model) to a queue;
//   the entry is popped and compared one edge later. Directed scenarios also
//   carry the literal grant index the arbiter must produce.
//   A second instance with N=5 checks the non-power-of-two case.
// ---------------------------------------------------------------------------
module tb_rr_arbiter;

    localparam int N     = 8;
    localparam int IDX_W = 3;
`ifdef RR_ARBITER_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [N-1:0]     req = '0;
    logic             enable = 1'b0;
    logic             lock = 1'b0;
    logic [N-1:0]     gnt;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_valid;

    logic             reset5 = 1'b1;
    logic [4:0]       req5 = '0;
    logic             enable5 = 1'b1;
    logic             lock5 = 1'b0;
    logic [4:0]       gnt5;
    logic [2:0]       gnt_idx5;
    logic             gnt_valid5;

    always #5 clk = ~clk;

    rr_arbiter #(.N(N), .IDX_W(IDX_W)) dut (
        .clk(clk), .reset(reset), .req(req), .enable(enable), .lock(lock),
        .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid)
    );

    rr_arbiter #(.N(5), .IDX_W(3)) dut5 (
        .clk(clk), .reset(reset5), .req(req5), .enable(enable5), .lock(lock5),
        .gnt(gnt5), .gnt_idx(gnt_idx5), .gnt_valid(gnt_valid5)
    );

    typedef struct {
        logic [N-1:0]     gnt;
        logic [IDX_W-1:0] idx;
        logic             v;
    } exp_t;

    typedef struct {
        logic         rst;
        logic [N-1:0] rq;
        logic         en;
        logic         lk;
        int           sx;   // required grant index, -1 = no grant
    } stim_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // reference model state
    int   m_ptr   = 0;
    int   m_idx   = 0;
    bit   m_valid = 1'b0;

    function automatic stim_t mk(logic r, logic [N-1:0] rq, logic en, logic lk, int sx);
        stim_t s;
        s.rst = r; s.rq = rq; s.en = en; s.lk = lk; s.sx = sx;
        return s;
    endfunction

    // Drive one cycle, predict outputs after the edge, then sample at edge+1.
    task automatic step(input stim_t s);
        exp_t e;
        bit   got;
        int   c;
        reset  = s.rst;
        req    = s.rq;
        enable = s.en;
        lock   = s.lk;
        got    = 1'b0;
        if (s.rst) begin
            m_ptr = 0; m_idx = 0; m_valid = 1'b0;
        end else if (!s.en) begin
            m_idx = 0; m_valid = 1'b0;
        end else if (LOCK_EN && m_valid && s.lk && s.rq[m_idx]) begin
            m_valid = 1'b1;
        end else begin
            for (int k = 0; k < N; k++) begin
                c = (m_ptr + k) % N;
                if (!got && s.rq[c]) begin
                    got   = 1'b1;
                    m_idx = c;
                end
            end
            if (got) begin
                m_valid = 1'b1;
                m_ptr   = (m_idx + 1) % N;
            end else begin
                m_valid = 1'b0;
                m_idx   = 0;
            end
        end
        e.v   = m_valid;
        e.idx = IDX_W'(m_idx);
        e.gnt = m_valid ? (N'(1) << m_idx) : '0;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step(mk(1'b1, '0, 1'b0, 1'b0, -1));
        sb.delete();
    endtask

    task automatic test_reset();
        exp_t e;
        // reset must win over enable, lock and requests
        for (int i = 0; i < 2; i++) begin
            step(mk(1'b1, 8'hFF, 1'b1, 1'b1, -1));
            e = sb.pop_front();
            n_checks++;
            if (gnt !== e.gnt || gnt_idx !== e.idx || gnt_valid !== e.v ||
                gnt !== '0 || gnt_idx !== '0 || gnt_valid !== 1'b0)
                $display("FAIL reset[%0d]: gnt=%h idx=%0d v=%b, required 00/0/0", i, gnt, gnt_idx, gnt_valid);
            else begin
                n_pass++;
                $display("ok reset[%0d] gnt=%h idx=%0d v=%b", i, gnt, gnt_idx, gnt_valid);
            end
        end
        sb.delete();
    endtask

    task automatic run_list(input string name, input stim_t s[$]);
        exp_t             e;
        logic [N-1:0]     sg;
        logic [IDX_W-1:0] si;
        logic             sv;
        foreach (s[i]) begin
            step(s[i]);
            e  = sb.pop_front();
            sv = (s[i].sx >= 0);
            sg = sv ? (N'(1) << s[i].sx) : '0;
            si = sv ? IDX_W'(s[i].sx) : '0;
            n_checks++;
            if (gnt !== e.gnt || gnt_idx !== e.idx || gnt_valid !== e.v ||
                gnt !== sg || gnt_idx !== si || gnt_valid !== sv)
                $display("FAIL %s[%0d]: gnt=%h idx=%0d v=%b, required gnt=%h idx=%0d v=%b (model %h/%0d/%b)",
                         name, i, gnt, gnt_idx, gnt_valid, sg, si, sv, e.gnt, e.idx, e.v);
            else begin
                n_pass++;
                $display("ok %s[%0d] req=%h en=%b lk=%b -> gnt=%h idx=%0d v=%b",
                         name, i, s[i].rq, s[i].en, s[i].lk, gnt, gnt_idx, gnt_valid);
            end
        end
    endtask

    task automatic test_rotate();
        stim_t s[$];
        do_reset();
        for (int i = 0; i < 9; i++) s.push_back(mk(1'b0, 8'hFF, 1'b1, 1'b0, i % 8));
        run_list("rotate", s);
    endtask

    task automatic test_wrap_pair();
        stim_t s[$];
        do_reset();
        for (int i = 0; i < 8; i++) s.push_back(mk(1'b0, 8'hFF, 1'b1, 1'b0, i));
        for (int i = 0; i < 4; i++) s.push_back(mk(1'b0, 8'h81, 1'b1, 1'b0, (i % 2 == 0) ? 0 : 7));
        run_list("wrap_pair", s);
    endtask

    task automatic test_lock();
        stim_t s[$];
        do_reset();
        for (int i = 0; i < 4; i++) s.push_back(mk(1'b0, 8'hFF, 1'b1, 1'b0, i));
        for (int i = 0; i < 5; i++) s.push_back(mk(1'b0, 8'hFF, 1'b1, 1'b1, LOCK_EN ? 3 : (4 + i) % 8));
        s.push_back(mk(1'b0, 8'hFF, 1'b1, 1'b0, LOCK_EN ? 4 : 1));
        // owner drops its request while lock stays high: lock releases
        s.push_back(mk(1'b0, 8'hFF, 1'b1, 1'b1, LOCK_EN ? 4 : 2));
        s.push_back(mk(1'b0, LOCK_EN ? 8'hEF : 8'hFB, 1'b1, 1'b1, LOCK_EN ? 5 : 3));
        run_list("lock", s);
    endtask

    task automatic test_enable();
        stim_t s[$];
        do_reset();
        for (int i = 0; i < 3; i++) s.push_back(mk(1'b0, 8'hFF, 1'b1, 1'b0, i));
        for (int i = 0; i < 3; i++) s.push_back(mk(1'b0, 8'hFF, 1'b0, 1'b1, -1));
        s.push_back(mk(1'b0, 8'hFF, 1'b1, 1'b0, 3));
        run_list("enable", s);
    endtask

    task automatic test_reset_mid_lock();
        stim_t s[$];
        do_reset();
        for (int i = 0; i < 6; i++) s.push_back(mk(1'b0, 8'hFF, 1'b1, 1'b0, i));
        s.push_back(mk(1'b0, 8'hFF, 1'b1, 1'b1, LOCK_EN ? 5 : 6));
        s.push_back(mk(1'b0, 8'hFF, 1'b1, 1'b1, LOCK_EN ? 5 : 7));
        s.push_back(mk(1'b1, 8'hFF, 1'b1, 1'b1, -1));
        s.push_back(mk(1'b0, 8'hFF, 1'b1, 1'b0, 0));
        run_list("reset_mid_lock", s);
    endtask

    task automatic test_drop();
        stim_t s[$];
        do_reset();
        for (int i = 0; i < 3; i++) s.push_back(mk(1'b0, 8'h10, 1'b1, 1'b0, 4));
        s.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, -1));
        s.push_back(mk(1'b0, 8'h24, 1'b1, 1'b0, 5));
        s.push_back(mk(1'b0, 8'h04, 1'b1, 1'b0, 2));
        s.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, -1));
        run_list("drop", s);
    endtask

    task automatic test_random();
        exp_t  e;
        stim_t s;
        do_reset();
        for (int i = 0; i < 300; i++) begin
            s = mk(($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0, N'($urandom),
                   ($urandom_range(0, 9) != 0) ? 1'b1 : 1'b0, 1'($urandom), 0);
            if ($urandom_range(0, 3) == 0) s.rq = '0;
            step(s);
            e = sb.pop_front();
            n_checks++;
            if (gnt !== e.gnt || gnt_idx !== e.idx || gnt_valid !== e.v)
                $display("FAIL random[%0d]: gnt=%h idx=%0d v=%b, required gnt=%h idx=%0d v=%b",
                         i, gnt, gnt_idx, gnt_valid, e.gnt, e.idx, e.v);
            else begin
                n_pass++;
                $display("ok random[%0d] req=%h en=%b lk=%b rst=%b -> gnt=%h idx=%0d v=%b",
                         i, s.rq, s.en, s.lk, s.rst, gnt, gnt_idx, gnt_valid);
            end
        end
    endtask

    task automatic test_n5();
        logic [4:0] rq;
        logic [4:0] req5_list [3];
        int         idx5_list [3];
        req5_list = '{5'b00000, 5'b10000, 5'b00001};
        idx5_list = '{-1, 4, 0};
        reset5 = 1'b1;
        req5   = 5'b11111;
        @(posedge clk); #1;
        reset5 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req5 = req5_list[i];
            @(posedge clk); #1;
            n_checks++;
            if ((idx5_list[i] < 0 && (gnt_valid5 !== 1'b0 || gnt5 !== '0 || gnt_idx5 !== '0)) ||
                (idx5_list[i] >= 0 && (gnt_valid5 !== 1'b1 || gnt_idx5 !== 3'(idx5_list[i]) ||
                                       gnt5 !== (5'd1 << idx5_list[i]))))
                $display("FAIL n5[%0d]: gnt=%h idx=%0d v=%b, required idx=%0d", i, gnt5, gnt_idx5, gnt_valid5, idx5_list[i]);
            else begin
                n_pass++;
                $display("ok n5[%0d] req=%b -> gnt=%b idx=%0d v=%b", i, req5, gnt5, gnt_idx5, gnt_valid5);
            end
        end
        for (int i = 0; i < 100; i++) begin
            rq   = 5'($urandom);
            req5 = rq;
            @(posedge clk); #1;
            n_checks++;
            if (gnt_valid5 !== (rq != 0) || gnt_idx5 >= 3'd5 ||
                (gnt_valid5 && (gnt5 !== (5'd1 << gnt_idx5) || !rq[gnt_idx5])) ||
                (!gnt_valid5 && (gnt5 !== '0 || gnt_idx5 !== '0)))
                $display("FAIL n5_random[%0d]: req=%b gnt=%b idx=%0d v=%b, required in-range one-hot grant to a requester",
                         i, rq, gnt5, gnt_idx5, gnt_valid5);
            else begin
                n_pass++;
                $display("ok n5_random[%0d] req=%b -> gnt=%b idx=%0d v=%b", i, rq, gnt5, gnt_idx5, gnt_valid5);
            end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_rotate();
        test_wrap_pair();
        test_lock();
        test_enable();
        test_reset_mid_lock();
        test_drop();
        test_random();
        test_n5();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
